// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the streaming Sobel filter.
package sobel_pkg;

  localparam logic [1:0] MODE_SAT    = 2'b00;
  localparam logic [1:0] MODE_SCALE  = 2'b01;
  localparam logic [1:0] MODE_THRESH = 2'b10;

  // Gradient width: signed range of +/-4*(2^PIX_W-1) fits in PIX_W+3 bits.
  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic logic [31:0] sat_u(input logic [31:0] v, input int pix_w);
    logic [31:0] max_v;
    max_v = (32'd1 << pix_w) - 32'd1;
    return (v > max_v) ? max_v : v;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two line-deep row store: returns the pixels of rows r-1 and r-2 at the
// addressed column, then shifts the new pixel in (read-before-write).
module sobel_line_buffer #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(IMG_W)-1:0]   addr,
  input  logic [PIX_W-1:0]           wdata,
  output logic [PIX_W-1:0]           row1,
  output logic [PIX_W-1:0]           row2
);

  logic [PIX_W-1:0] mem1 [IMG_W];
  logic [PIX_W-1:0] mem2 [IMG_W];

  assign row1 = mem1[addr];
  assign row2 = mem2[addr];

  // Contents are never reset; every entry is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem1[addr] <= wdata;
      mem2[addr] <= mem1[addr];
    end
  end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel magnitude filter: raster pixels in, interior pixels out
// with coordinates, two pipeline stages after the accepting edge.
module sobel_stream_filter
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refresh,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pix,
  input  logic [1:0]       mode,
  input  logic [PIX_W-1:0] threshold,
  output logic             out_valid,
  output logic [PIX_W-1:0] out_pix,
  output logic [XW-1:0]    out_x,
  output logic [YW-1:0]    out_y,
  output logic             frame_done
);

  localparam int GW = grad_w(PIX_W);

  // Handshake: in_valid alone accepts a pixel (no ready); out_valid is a
  // one-cycle qualifier with no backpressure from the consumer.
  logic             accept;
  logic [XW-1:0]    col;
  logic [YW-1:0]    row;
  logic             col_last, row_last;
  logic [1:0]       mode_q;
  logic [PIX_W-1:0] thr_q;
  logic [PIX_W-1:0] lb_row1, lb_row2;

  assign accept   = in_valid & ~refresh;
  assign col_last = (col == XW'(IMG_W - 1));
  assign row_last = (row == YW'(IMG_H - 1));

  sobel_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (in_pix),
    .row1  (lb_row1),
    .row2  (lb_row2)
  );

  always_ff @(posedge clk) begin
    if (rst || refresh) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + YW'(1);
      end else begin
        col <= col + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_SAT;
      thr_q  <= '0;
    end else if (accept && col == '0 && row == '0) begin
      mode_q <= mode;
      thr_q  <= threshold;
    end
  end

  // Window p0..p8 row-major; the rightmost column enters from the line buffer.
  logic [PIX_W-1:0] win [9];
  logic             win_valid, win_last;
  logic [XW-1:0]    win_x;
  logic [YW-1:0]    win_y;
  logic [1:0]       win_mode;
  logic [PIX_W-1:0] win_thr;

  always_ff @(posedge clk) begin
    if (accept) begin
      win[0]   <= win[1];
      win[1]   <= win[2];
      win[2]   <= lb_row2;
      win[3]   <= win[4];
      win[4]   <= win[5];
      win[5]   <= lb_row1;
      win[6]   <= win[7];
      win[7]   <= win[8];
      win[8]   <= in_pix;
      win_x    <= col - XW'(1);
      win_y    <= row - YW'(1);
      win_last <= col_last & row_last;
      win_mode <= mode_q;
      win_thr  <= thr_q;
    end
  end

  function automatic logic [GW-1:0] ext(input logic [PIX_W-1:0] p);
    return GW'(p);
  endfunction

  logic signed [GW-1:0] gx_c, gy_c;
  assign gx_c = signed'(ext(win[2]) + (ext(win[5]) << 1) + ext(win[8])
                      - ext(win[0]) - (ext(win[3]) << 1) - ext(win[6]));
  assign gy_c = signed'(ext(win[6]) + (ext(win[7]) << 1) + ext(win[8])
                      - ext(win[0]) - (ext(win[1]) << 1) - ext(win[2]));

  logic                 s1_valid, s1_last;
  logic signed [GW-1:0] s1_gx, s1_gy;
  logic [XW-1:0]        s1_x;
  logic [YW-1:0]        s1_y;
  logic [1:0]           s1_mode;
  logic [PIX_W-1:0]     s1_thr;

  always_ff @(posedge clk) begin
    s1_gx   <= gx_c;
    s1_gy   <= gy_c;
    s1_x    <= win_x;
    s1_y    <= win_y;
    s1_last <= win_last;
    s1_mode <= win_mode;
    s1_thr  <= win_thr;
  end

  always_ff @(posedge clk) begin
    if (rst || refresh) begin
      win_valid <= 1'b0;
      s1_valid  <= 1'b0;
    end else begin
      win_valid <= accept && row >= YW'(2) && col >= XW'(2);
      s1_valid  <= win_valid;
    end
  end

  logic [GW-1:0]    ax, ay, mag;
  logic [PIX_W-1:0] res;

  assign ax  = s1_gx[GW-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
  assign ay  = s1_gy[GW-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
  assign mag = ax + ay;

  always_comb begin
    res = PIX_W'(sat_u(32'(mag), PIX_W));
    case (s1_mode)
      MODE_SCALE:  res = PIX_W'(sat_u(32'(mag >> 3), PIX_W));
      MODE_THRESH: res = (mag >= GW'(s1_thr)) ? {PIX_W{1'b1}} : '0;
      default:     res = PIX_W'(sat_u(32'(mag), PIX_W));
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      out_pix    <= '0;
      out_x      <= '0;
      out_y      <= '0;
    end else if (refresh) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= s1_valid;
      frame_done <= s1_valid & s1_last;
      if (s1_valid) begin
        out_pix <= res;
        out_x   <= s1_x;
        out_y   <= s1_y;
      end
    end
  end

endmodule
